// File: rtl/ddr_cmd_sequencer_if.sv
// Command/request bundle between the DDR command sequencer, its two host
// requesters and the downstream control interface.
interface ddr_cmd_sequencer_if #(
  parameter int unsigned ASIZE = 23
);
  logic [2:0]       cmd;
  logic [ASIZE-1:0] addr;
  logic             cmd_ack;
  logic             req0;
  logic             req1;
  logic             wr0;
  logic             wr1;
  logic [ASIZE-1:0] raddr0;
  logic [ASIZE-1:0] raddr1;
  logic             gnt0;
  logic             gnt1;
  logic             init_done;
  logic             err;

  modport master (
    output cmd, addr, gnt0, gnt1, init_done, err,
    input  cmd_ack, req0, req1, wr0, wr1, raddr0, raddr1
  );

  modport slave (
    input  cmd, addr, gnt0, gnt1, init_done, err,
    output cmd_ack, req0, req1, wr0, wr1, raddr0, raddr1
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Drives the DDR control interface: power-up configuration sequence, then
// round-robin READA/WRITEA issue for two host ports, with ack watchdog/retry.
module ddr_cmd_sequencer #(
  parameter int unsigned      ASIZE       = 23,
  parameter logic [ASIZE-1:0] CFG_REG1    = 23'h000D31,
  parameter logic [ASIZE-1:0] CFG_REG2    = 23'h000618,
  parameter logic [ASIZE-1:0] MODE_WORD   = 23'h000022,
  parameter int unsigned      INIT_CYCLES = 200,
  parameter int unsigned      ACK_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  ddr_cmd_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    StWait, StInitIssue, StInitGap, StIdle, StIssue, StGap
  } state_e;

  localparam logic [2:0] CmdNop       = 3'b000;
  localparam logic [2:0] CmdRead      = 3'b001;
  localparam logic [2:0] CmdWrite     = 3'b010;
  localparam logic [2:0] CmdRefresh   = 3'b011;
  localparam logic [2:0] CmdPrecharge = 3'b100;
  localparam logic [2:0] CmdLoadMode  = 3'b101;
  localparam logic [2:0] CmdLoadReg1  = 3'b110;
  localparam logic [2:0] CmdLoadReg2  = 3'b111;

  localparam logic [ASIZE-1:0] PrechargeAll = {{(ASIZE-11){1'b0}}, 1'b1, 10'b0};
  localparam logic [7:0]       WdogLast     = 8'(ACK_TIMEOUT - 1);
  localparam logic [15:0]      InitLoad     = 16'(INIT_CYCLES);

  state_e           state_q;
  logic [15:0]      init_cnt_q;
  logic [7:0]       wdog_q;
  logic [2:0]       step_q;
  logic             acked_q;
  logic             last_q;
  logic             port_q;
  logic [2:0]       cmd_q;
  logic [ASIZE-1:0] addr_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             init_done_q;
  logic             err_q;

  logic [2:0]       next_step;
  logic             pick;
  logic             sel_wr;
  logic [ASIZE-1:0] sel_addr;

  function automatic logic [2:0] init_cmd(input logic [2:0] s);
    case (s)
      3'd0:       return CmdLoadReg1;
      3'd1:       return CmdLoadReg2;
      3'd2:       return CmdPrecharge;
      3'd3, 3'd4: return CmdRefresh;
      default:    return CmdLoadMode;
    endcase
  endfunction

  function automatic logic [ASIZE-1:0] init_addr(input logic [2:0] s);
    case (s)
      3'd0:       return CFG_REG1;
      3'd1:       return CFG_REG2;
      3'd2:       return PrechargeAll;
      3'd3, 3'd4: return '0;
      default:    return MODE_WORD;
    endcase
  endfunction

  // A timed-out step is reissued rather than advanced.
  assign next_step = acked_q ? step_q + 3'd1 : step_q;

  always_comb begin
    pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    sel_wr   = pick ? bus.wr1 : bus.wr0;
    sel_addr = pick ? bus.raddr1 : bus.raddr0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StWait;
      init_cnt_q  <= InitLoad;
      wdog_q      <= 8'd0;
      step_q      <= 3'd0;
      acked_q     <= 1'b0;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      cmd_q       <= CmdNop;
      addr_q      <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (init_cnt_q == 16'd1) begin
            state_q <= StInitIssue;
            step_q  <= 3'd0;
            wdog_q  <= 8'd0;
            cmd_q   <= init_cmd(3'd0);
            addr_q  <= init_addr(3'd0);
          end else begin
            init_cnt_q <= init_cnt_q - 16'd1;
          end
        end
        StInitIssue: begin
          if (bus.cmd_ack || wdog_q == WdogLast) begin
            // Ack takes priority over a simultaneous watchdog expiry.
            if (!bus.cmd_ack) err_q <= 1'b1;
            acked_q <= bus.cmd_ack;
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            state_q <= StInitGap;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        StInitGap: begin
          if (acked_q && step_q == 3'd5) begin
            init_done_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            step_q  <= next_step;
            cmd_q   <= init_cmd(next_step);
            addr_q  <= init_addr(next_step);
            wdog_q  <= 8'd0;
            state_q <= StInitIssue;
          end
        end
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            port_q  <= pick;
            cmd_q   <= sel_wr ? CmdWrite : CmdRead;
            addr_q  <= sel_addr;
            wdog_q  <= 8'd0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (bus.cmd_ack) begin
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            gnt0_q  <= ~port_q;
            gnt1_q  <= port_q;
            last_q  <= port_q;
            state_q <= StGap;
          end else if (wdog_q == WdogLast) begin
            err_q   <= 1'b1;
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            state_q <= StGap;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StWait;
        end
      endcase
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.addr      = addr_q;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Scoreboard bench for ddr_cmd_sequencer: init sequence, arbitration, watchdog
// retry and asynchronous reset.
module tb_ddr_cmd_sequencer;
  localparam int unsigned ASIZE       = 23;
  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned ACK_TIMEOUT = 8;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic             port;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ddr_cmd_sequencer_if #(.ASIZE(ASIZE)) bus ();

  ddr_cmd_sequencer #(
    .ASIZE      (ASIZE),
    .INIT_CYCLES(INIT_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next non-NOP command; returns NOP on expiry.
  task automatic wait_cmd(output logic [2:0] c, output logic [ASIZE-1:0] a, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.cmd == 3'b000 && waited < 200);
    c = bus.cmd;
    a = bus.addr;
  endtask

  // Ack so that it is sampled on the n-th edge after the command appeared.
  task automatic ack_after(input int n, output int held, output logic [2:0] c_after,
                           output logic g0, output logic g1);
    logic [2:0] c0;
    c0   = bus.cmd;
    held = 1;
    for (int i = 1; i < n; i++) begin
      tick();
      if (bus.cmd !== c0) held = 0;
    end
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
    c_after = bus.cmd;
    g0      = bus.gnt0;
    g1      = bus.gnt1;
  endtask

  task automatic run_init();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h;
    exp_t e;
    exp_q.push_back({3'b110, 23'h000D31, 1'b0});
    exp_q.push_back({3'b111, 23'h000618, 1'b0});
    exp_q.push_back({3'b100, 23'h000400, 1'b0});
    exp_q.push_back({3'b011, 23'h000000, 1'b0});
    exp_q.push_back({3'b011, 23'h000000, 1'b0});
    exp_q.push_back({3'b101, 23'h000022, 1'b0});
    for (int s = 0; s < 6; s++) begin
      wait_cmd(c, a, w);
      e = exp_q.pop_front();
      total++;
      if (c !== e.cmd || a !== e.addr) begin
        bad++;
        $display("FAIL init_step%0d: got cmd=%b addr=%h, want cmd=%b addr=%h",
                 s, c, a, e.cmd, e.addr);
      end
      if (s > 0) begin
        total++;
        if (w !== 1) begin
          bad++;
          $display("FAIL init_gap%0d: got %0d NOP cycles, want 1", s, w);
        end
      end
      ack_after(3, h, ca, g0, g1);
      total++;
      if (h !== 1 || ca !== 3'b000 || g0 !== 1'b0 || g1 !== 1'b0) begin
        bad++;
        $display("FAIL init_ack%0d: got held=%0d cmd=%b gnt=%b%b, want held=1 cmd=000 gnt=00",
                 s, h, ca, g1, g0);
      end
      if (s == 5) begin
        total++;
        if (bus.init_done !== 1'b0) begin
          bad++;
          $display("FAIL init_done_early: got %b, want 0", bus.init_done);
        end
        tick();
        total++;
        if (bus.init_done !== 1'b1) begin
          bad++;
          $display("FAIL init_done_rise: got %b, want 1", bus.init_done);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (bus.cmd !== 3'b000 || bus.addr !== '0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
        bus.init_done !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got cmd=%b addr=%h gnt=%b%b done=%b err=%b, want all 0",
               bus.cmd, bus.addr, bus.gnt1, bus.gnt0, bus.init_done, bus.err);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_init();
    run_init();
  endtask

  task automatic test_single_write();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h;
    exp_t e;
    bus.req0   = 1'b1;
    bus.wr0    = 1'b1;
    bus.raddr0 = 23'h001234;
    exp_q.push_back({3'b010, 23'h001234, 1'b0});
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr) begin
      bad++;
      $display("FAIL single_cmd: got cmd=%b addr=%h, want cmd=%b addr=%h", c, a, e.cmd, e.addr);
    end
    ack_after(3, h, ca, g0, g1);
    bus.req0 = 1'b0;
    total++;
    if (h !== 1 || ca !== 3'b000 || g0 !== 1'b1 || g1 !== 1'b0) begin
      bad++;
      $display("FAIL single_ack: got held=%0d cmd=%b gnt1=%b gnt0=%b, want 1 000 0 1",
               h, ca, g1, g0);
    end
    tick();
    total++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL single_gnt_pulse: got gnt1=%b gnt0=%b, want 0 0", bus.gnt1, bus.gnt0);
    end
  endtask

  task automatic test_exact_timeout();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h;
    exp_t e;
    bus.req1   = 1'b1;
    bus.wr1    = 1'b0;
    bus.raddr1 = 23'h0ABCDE;
    exp_q.push_back({3'b001, 23'h0ABCDE, 1'b1});
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr) begin
      bad++;
      $display("FAIL edge_cmd: got cmd=%b addr=%h, want cmd=%b addr=%h", c, a, e.cmd, e.addr);
    end
    ack_after(ACK_TIMEOUT, h, ca, g0, g1);
    bus.req1 = 1'b0;
    total++;
    if (h !== 1 || ca !== 3'b000 || g1 !== 1'b1 || g0 !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL edge_ack: got held=%0d cmd=%b gnt1=%b gnt0=%b err=%b, want 1 000 1 0 0",
               h, ca, g1, g0, bus.err);
    end
    tick();
    total++;
    if (bus.err !== 1'b0 || bus.gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL edge_err: got err=%b gnt1=%b, want 0 0", bus.err, bus.gnt1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h;
    exp_t e;
    bus.req0   = 1'b1;
    bus.wr0    = 1'b0;
    bus.raddr0 = 23'h000111;
    bus.req1   = 1'b1;
    bus.wr1    = 1'b1;
    bus.raddr1 = 23'h000222;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({3'b001, 23'h000111, 1'b0});
      exp_q.push_back({3'b010, 23'h000222, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      wait_cmd(c, a, w);
      e = exp_q.pop_front();
      total++;
      if (c !== e.cmd || a !== e.addr) begin
        bad++;
        $display("FAIL rr_cmd%0d: got cmd=%b addr=%h, want cmd=%b addr=%h",
                 i, c, a, e.cmd, e.addr);
      end
      ack_after(2, h, ca, g0, g1);
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      total++;
      if (g0 !== ~e.port || g1 !== e.port || ca !== 3'b000) begin
        bad++;
        $display("FAIL rr_gnt%0d: got gnt1=%b gnt0=%b cmd=%b, want gnt1=%b gnt0=%b cmd=000",
                 i, g1, g0, ca, e.port, ~e.port);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h, held;
    exp_t e;
    bus.req0   = 1'b1;
    bus.wr0    = 1'b0;
    bus.raddr0 = 23'h000777;
    exp_q.push_back({3'b001, 23'h000777, 1'b0});
    exp_q.push_back({3'b001, 23'h000777, 1'b0});
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr) begin
      bad++;
      $display("FAIL wd_cmd: got cmd=%b addr=%h, want cmd=%b addr=%h", c, a, e.cmd, e.addr);
    end
    held = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.cmd == 3'b000) break;
      held++;
    end
    total++;
    if (held !== ACK_TIMEOUT || bus.err !== 1'b1 || bus.gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL wd_expire: got held=%0d err=%b gnt0=%b, want held=%0d err=1 gnt0=0",
               held, bus.err, bus.gnt0, ACK_TIMEOUT);
    end
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr) begin
      bad++;
      $display("FAIL wd_retry: got cmd=%b addr=%h, want cmd=%b addr=%h", c, a, e.cmd, e.addr);
    end
    ack_after(3, h, ca, g0, g1);
    bus.req0 = 1'b0;
    total++;
    if (g0 !== 1'b1 || g1 !== 1'b0 || bus.err !== 1'b1 || ca !== 3'b000) begin
      bad++;
      $display("FAIL wd_retry_ack: got gnt0=%b gnt1=%b err=%b cmd=%b, want 1 0 1 000",
               g0, g1, bus.err, ca);
    end
  endtask

  task automatic test_reset_mid_cmd();
    logic [2:0] c, ca;
    logic [ASIZE-1:0] a;
    logic g0, g1;
    int w, h;
    exp_t e;
    bus.req0   = 1'b1;
    bus.wr0    = 1'b1;
    bus.raddr0 = 23'h005555;
    exp_q.push_back({3'b010, 23'h005555, 1'b0});
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr) begin
      bad++;
      $display("FAIL rst_pre_cmd: got cmd=%b addr=%h, want cmd=%b addr=%h",
               c, a, e.cmd, e.addr);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.cmd !== 3'b000 || bus.addr !== '0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
        bus.init_done !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got cmd=%b addr=%h gnt=%b%b done=%b err=%b, want all 0",
               bus.cmd, bus.addr, bus.gnt1, bus.gnt0, bus.init_done, bus.err);
    end
    bus.req0   = 1'b0;
    bus.req1   = 1'b1;
    bus.wr1    = 1'b0;
    bus.raddr1 = 23'h000999;
    tick();
    tick();
    rst = 1'b0;
    run_init();
    exp_q.push_back({3'b001, 23'h000999, 1'b1});
    wait_cmd(c, a, w);
    e = exp_q.pop_front();
    total++;
    if (c !== e.cmd || a !== e.addr || bus.init_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_pending_cmd: got cmd=%b addr=%h done=%b, want cmd=%b addr=%h done=1",
               c, a, bus.init_done, e.cmd, e.addr);
    end
    ack_after(3, h, ca, g0, g1);
    bus.req1 = 1'b0;
    total++;
    if (g1 !== 1'b1 || g0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_pending_gnt: got gnt1=%b gnt0=%b, want 1 0", g1, g0);
    end
  endtask

  initial begin
    bus.cmd_ack = 1'b0;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.wr0     = 1'b0;
    bus.wr1     = 1'b0;
    bus.raddr0  = '0;
    bus.raddr1  = '0;
    test_reset();
    test_init();
    test_single_write();
    test_exact_timeout();
    test_back_to_back();
    test_timeout();
    test_reset_mid_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
